// File: rtl/FetchUnitTypes.sv
// Shared AX-BTB types: geometry constants, entry layout and sweep phases.
// Imported by the AX-BTB top and its invalidation sweep controller.
package FetchUnitTypes;

  localparam int AXBTB_ENTRY_NUM   = 256;
  localparam int AXBTB_INDEX_WIDTH = $clog2(AXBTB_ENTRY_NUM);
  localparam int AXBTB_TAG_WIDTH   = 8;
  localparam int AXBTB_ADDR_WIDTH  = 32;

  typedef logic [AXBTB_INDEX_WIDTH-1:0] AxBtbIndexPath;
  typedef logic [AXBTB_TAG_WIDTH-1:0]   AxBtbTagPath;

  typedef struct packed {
    logic                        valid;
    AxBtbTagPath                 tag;
    logic [AXBTB_ADDR_WIDTH-1:0] target;
  } AxBtbEntry;

  typedef enum logic [1:0] {
    AXBTB_INIT,
    AXBTB_READY,
    AXBTB_CLEAR
  } AxBtbPhase;

endpackage

// File: rtl/ax_btb_clear_fsm.sv
// AX-BTB invalidation sweep: one valid bit per cycle after reset
// and on a clear request; ready is low while the sweep runs.
module ax_btb_clear_fsm
  import FetchUnitTypes::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear_req,
  output logic          o_ready,
  output logic          o_clr_en,
  output AxBtbIndexPath o_clr_idx
);

  AxBtbPhase     r_phase;
  AxBtbIndexPath r_cnt;
  logic          r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= AXBTB_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      unique case (r_phase)
        AXBTB_READY: begin
          if (i_clear_req) begin
            r_phase <= AXBTB_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
          end
        end
        AXBTB_INIT, AXBTB_CLEAR: begin
          r_cnt <= r_cnt + AxBtbIndexPath'(1);
          // Counter wrap ends the sweep.
          if (&r_cnt) begin
            r_phase <= AXBTB_READY;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_phase <= AXBTB_INIT;
          r_cnt   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready   = r_ready;
  assign o_clr_en  = ~r_ready;
  assign o_clr_idx = r_cnt;

endmodule

// File: rtl/ax_btb.sv
// Approximate-branch target buffer: direct-mapped, multi-lane lookup
// issued in NextPC, registered hit/target presented in Fetch.
module ax_btb
  import FetchUnitTypes::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ENTRY_NUM   = AXBTB_ENTRY_NUM,
  parameter int TAG_WIDTH   = AXBTB_TAG_WIDTH,
  parameter int ADDR_WIDTH  = AXBTB_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rdEn,
  input  logic [ADDR_WIDTH-1:0]         rdPC,
  input  logic [FETCH_WIDTH-1:0]        rdLaneValid,
  input  logic                          fetchStall,
  input  logic                          fetchFlush,
  input  logic                          wrEn,
  input  logic [ADDR_WIDTH-1:0]         wrPC,
  input  logic [ADDR_WIDTH-1:0]         wrTarget,
  input  logic                          wrAlloc,
  input  logic                          clearReq,
  output logic [FETCH_WIDTH-1:0]        axbtbHit,
  output logic [FETCH_WIDTH*ADDR_WIDTH-1:0] axbtbTarget,
  output logic                          ready
);

  localparam int IW = $clog2(ENTRY_NUM);
  localparam int TW = TAG_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int KW = IW + TW;

  logic [ENTRY_NUM-1:0] r_valid;
  AxBtbTagPath          r_tag    [ENTRY_NUM];
  logic [AW-1:0]        r_target [ENTRY_NUM];

  logic          w_ready;
  logic          w_clr_en;
  AxBtbIndexPath w_clr_idx;

  ax_btb_clear_fsm u_clear_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear_req (clearReq),
    .o_ready     (w_ready),
    .o_clr_en    (w_clr_en),
    .o_clr_idx   (w_clr_idx)
  );

  AxBtbIndexPath w_wr_idx;
  AxBtbTagPath   w_wr_tag;
  logic          w_wr_ok;

  assign w_wr_idx = wrPC[2 +: IW];
  assign w_wr_tag = wrPC[2+IW +: TW];
  assign w_wr_ok  = wrEn & w_ready;

  AxBtbIndexPath          w_rd_idx [FETCH_WIDTH];
  AxBtbTagPath            w_rd_tag [FETCH_WIDTH];
  AxBtbEntry              w_rd     [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] w_hit;

  // Lane i sits 4*i bytes ahead: add i above the byte offset.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      {w_rd_tag[i], w_rd_idx[i]} = rdPC[2 +: KW] + KW'(i);
      w_rd[i].valid  = r_valid[w_rd_idx[i]];
      w_rd[i].tag    = r_tag[w_rd_idx[i]];
      w_rd[i].target = r_target[w_rd_idx[i]];
      w_hit[i] = rdLaneValid[i] & w_rd[i].valid &
                 (w_rd[i].tag == w_rd_tag[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (w_clr_en) begin
      r_valid[w_clr_idx] <= 1'b0;
    end else if (wrEn) begin
      if (wrAlloc)
        r_valid[w_wr_idx] <= 1'b1;
      else if (r_tag[w_wr_idx] == w_wr_tag)
        r_valid[w_wr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok & wrAlloc) begin
      r_tag[w_wr_idx]    <= w_wr_tag;
      r_target[w_wr_idx] <= wrTarget;
    end
  end

  logic [FETCH_WIDTH-1:0]    r_hit;
  logic [FETCH_WIDTH*AW-1:0] r_tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit <= '0;
      r_tgt <= '0;
    end else if (!w_ready) begin
      r_hit <= '0;
    end else if (!fetchStall) begin
      if (fetchFlush || !rdEn) begin
        r_hit <= '0;
      end else begin
        r_hit <= w_hit;
        for (int i = 0; i < FETCH_WIDTH; i++)
          r_tgt[i*AW +: AW] <= w_rd[i].target;
      end
    end
  end

  // Gate with ready so a clear request hides a held hit at once.
  assign axbtbHit    = r_hit & {FETCH_WIDTH{w_ready}};
  assign axbtbTarget = r_tgt;
  assign ready       = w_ready;

  logic w_unused;
  assign w_unused = ^{rdPC[1:0], rdPC[AW-1:2+KW],
                      wrPC[1:0], wrPC[AW-1:2+KW]};

endmodule
